div_wb_queue: RTL and testbench
===============================

# div_wb_queue

Result buffer between the divider and the common data bus (CDB). It captures each divider result (rob_idx, rd, data) into an in-order queue and requests the CDB from the writeback arbiter. Entries leave the queue when the CDB grant arrives. Its ready output drives the divider's `div_i_ready`, so the divider pipeline freezes only when this queue is full. It also discards results belonging to squashed instructions on a mispredict.

## Interface
Parameters:
- `ROB_LEN`, default 16: number of ROB entries; sets the width of `flush_mask`.
- `ROB_IDX_W`, default `$clog2(ROB_LEN)`: width of a ROB index.
- `DEPTH`, default 4: number of queue entries; must be at least 2.

Ports (clock and reset first):
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: divider result valid (`div_o_valid`).
- `in_rob_idx`, input, ROB_IDX_W: ROB index of the result.
- `in_rd`, input, 7: destination physical register.
- `in_data`, input, 32: result data.
- `in_ready`, output, 1: queue can accept a result this cycle; connects to the divider's `div_i_ready`.
- `mispredict`, input, 1: flush strobe.
- `flush_mask`, input, ROB_LEN: bit i set means ROB entry i is squashed.
- `cdb_req`, output, 1: head entry valid; requests the CDB.
- `cdb_rob_idx`, output, ROB_IDX_W: head entry ROB index.
- `cdb_rd`, output, 7: head entry rd.
- `cdb_data`, output, 32: head entry data.
- `cdb_gnt`, input, 1: arbiter grant for this cycle.
- `occupancy`, output, $clog2(DEPTH+1): number of valid entries.

## Operation
- Storage is an in-order compacting queue. Slot 0 is the head. Slots 0..occupancy-1 are valid.
- `in_ready = (occupancy != DEPTH)`. It is computed from registered state only and has no combinational path from `cdb_gnt` or `mispredict`.
- A push occurs when `in_valid & in_ready`. `in_valid` while `in_ready` is 0 is a protocol error. The divider never does this, because it masks its valid with `~stall`.
- A pop occurs when `cdb_req & cdb_gnt`. `cdb_gnt` while `cdb_req` is 0 is ignored.
- `cdb_req = valid[0] & ~(mispredict & flush_mask[rob_idx[0]])`. A head that is being flushed in the same cycle never raises a request.
- Each cycle, the next state is built in this order:
  1. Take the current entries.
  2. Remove slot 0 if a pop occurs.
  3. If `mispredict`, remove every entry whose `flush_mask[rob_idx]` is set.
  4. Compact the survivors toward slot 0, preserving their relative order.
  5. Append the pushed entry at the first free slot, unless `mispredict & flush_mask[in_rob_idx]`, in which case the incoming entry is dropped.
- Priority: `rst` > flush/pop removal > push append.
- `occupancy` is the registered count of survivors plus the appended entry.
- Data, rd and rob_idx are never modified while an entry is held.
- Output fields for an invalid head are don't-care; the bench compares them only when `cdb_req` is 1.

## Timing
- Reset values:
  - `occupancy` = 0 and all valid bits = 0.
  - `cdb_req` = 0.
  - `in_ready` = 1 from the first cycle after reset.
  - `cdb_rob_idx`, `cdb_rd` and `cdb_data` = 0.
- Latency: a result pushed at edge N appears on `cdb_req` and the cdb fields in the cycle after edge N, when the queue was empty. There is no input-to-CDB bypass.
- Throughput: one push and one pop per cycle. With continuous grants, occupancy stays at 1 and `in_ready` stays high.
- Full: `in_ready` = 0 while occupancy = DEPTH. A pop in that cycle frees a slot, and `in_ready` returns to 1 the following cycle. There is no push in the full cycle.
- Simultaneous pop and push at occupancy k (1 ≤ k < DEPTH): occupancy stays k. The new entry lands in slot k-1.
- Mispredict concurrent with a grant on an unflushed head: the pop happens and the flush applies to the remaining entries.
- Mispredict that flushes all entries plus the incoming one: occupancy = 0 next cycle.
- `rst` asserted mid-operation: all entries are discarded at that edge, and any grant in that cycle is ignored.

## Test plan
- Single result: push (rob 3, rd 10, data 0x0000_0007) into an empty queue, hold `cdb_gnt` = 1 -> `cdb_req` = 1 for exactly one cycle, one cycle after the push, with the same fields; occupancy returns to 0.
- Fill and stall: push 4 results with `cdb_gnt` = 0 -> occupancy = 4 and `in_ready` = 0. Then grant once -> `in_ready` = 1 the next cycle, and the entries drain in push order.
- Push and pop in the same cycle at occupancy 2 -> occupancy stays 2 and order is preserved: the old second entry is at the head next cycle.
- Selective flush: queue holds rob {1,2,5}, incoming rob 6; `mispredict` with `flush_mask` bits 2 and 6 set -> next cycle the queue holds {1,5}, occupancy = 2, and rob 2 is never requested.
- Head flush with grant: head rob 4 flushed while `cdb_gnt` = 1 -> `cdb_req` = 0 in that cycle, no pop is counted, and the next head is requested the following cycle.
- Reset with 3 entries held and a grant pending -> the next cycle has occupancy = 0, `cdb_req` = 0 and `in_ready` = 1.

Source files
------------

// File: rtl/div_wb_queue.sv
// div_wb_queue: in-order compacting result buffer between the divider and the CDB.
// Slot 0 is the head; slots 0..occupancy-1 hold valid entries.
module div_wb_queue #(
  parameter int unsigned ROB_LEN   = 16,
  parameter int unsigned ROB_IDX_W = $clog2(ROB_LEN),
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [ROB_IDX_W-1:0]         in_rob_idx,
  input  logic [6:0]                   in_rd,
  input  logic [31:0]                  in_data,
  output logic                         in_ready,
  input  logic                         mispredict,
  input  logic [ROB_LEN-1:0]           flush_mask,
  output logic                         cdb_req,
  output logic [ROB_IDX_W-1:0]         cdb_rob_idx,
  output logic [6:0]                   cdb_rd,
  output logic [31:0]                  cdb_data,
  input  logic                         cdb_gnt,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned RD_W   = 7;
  localparam int unsigned DATA_W = 32;

  logic [ROB_IDX_W-1:0] r_rob  [DEPTH];
  logic [RD_W-1:0]      r_rd   [DEPTH];
  logic [DATA_W-1:0]    r_data [DEPTH];
  logic [OCC_W-1:0]     r_occ;

  logic [ROB_IDX_W-1:0] w_n_rob  [DEPTH];
  logic [RD_W-1:0]      w_n_rd   [DEPTH];
  logic [DATA_W-1:0]    w_n_data [DEPTH];
  logic [OCC_W-1:0]     w_n_cnt;
  logic                 w_keep;
  logic                 w_push;
  logic                 w_pop;

  // Handshake and head request; a head being flushed this cycle never requests.
  always_comb begin
    in_ready    = (r_occ != OCC_W'(DEPTH));
    cdb_req     = (r_occ != '0) && !(mispredict && flush_mask[r_rob[0]]);
    w_push      = in_valid && in_ready;
    w_pop       = cdb_req && cdb_gnt;
    cdb_rob_idx = r_rob[0];
    cdb_rd      = r_rd[0];
    cdb_data    = r_data[0];
    occupancy   = r_occ;
  end

  // Next state: drop popped head and flushed entries, compact, then append the push.
  always_comb begin
    w_n_rob  = r_rob;
    w_n_rd   = r_rd;
    w_n_data = r_data;
    w_n_cnt  = '0;
    w_keep   = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_keep = (OCC_W'(i) < r_occ)
               && !(w_pop && (i == 0))
               && !(mispredict && flush_mask[r_rob[i]]);
      if (w_keep) begin
        w_n_rob[IDX_W'(w_n_cnt)]  = r_rob[i];
        w_n_rd[IDX_W'(w_n_cnt)]   = r_rd[i];
        w_n_data[IDX_W'(w_n_cnt)] = r_data[i];
        w_n_cnt = w_n_cnt + OCC_W'(1);
      end
    end
    if (w_push && !(mispredict && flush_mask[in_rob_idx])) begin
      w_n_rob[IDX_W'(w_n_cnt)]  = in_rob_idx;
      w_n_rd[IDX_W'(w_n_cnt)]   = in_rd;
      w_n_data[IDX_W'(w_n_cnt)] = in_data;
      w_n_cnt = w_n_cnt + OCC_W'(1);
    end
  end

  // Queue storage and count; reset discards everything, including a pending grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_rob[i]  <= '0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_occ  <= w_n_cnt;
      r_rob  <= w_n_rob;
      r_rd   <= w_n_rd;
      r_data <= w_n_data;
    end
  end

endmodule

// File: tb/tb_div_wb_queue.sv
// tb_div_wb_queue: directed stimulus, queue-based reference model, per-cycle compare.
module tb_div_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_rob_idx;
  logic [6:0]  in_rd;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mispredict;
  logic [15:0] flush_mask;
  logic        cdb_req;
  logic [3:0]  cdb_rob_idx;
  logic [6:0]  cdb_rd;
  logic [31:0] cdb_data;
  logic        cdb_gnt;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  div_wb_queue #(.ROB_LEN(16), .ROB_IDX_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rob_idx(in_rob_idx), .in_rd(in_rd), .in_data(in_data),
    .in_ready(in_ready),
    .mispredict(mispredict), .flush_mask(flush_mask),
    .cdb_req(cdb_req), .cdb_rob_idx(cdb_rob_idx), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
    .cdb_gnt(cdb_gnt), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain ordered list of held results.
  typedef struct {
    logic [3:0]  rob;
    logic [6:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t m_q[$];
  ent_t m_tmp[$];
  ent_t m_new;
  int   m_n0;
  bit   m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_live = 1'b1;
    end else begin
      m_n0 = m_q.size();
      if (m_n0 > 0 && cdb_gnt && !(mispredict && flush_mask[m_q[0].rob]))
        void'(m_q.pop_front());
      if (mispredict) begin
        m_tmp.delete();
        foreach (m_q[i]) if (!flush_mask[m_q[i].rob]) m_tmp.push_back(m_q[i]);
        m_q = m_tmp;
      end
      if (in_valid && m_n0 < DEPTH && !(mispredict && flush_mask[in_rob_idx])) begin
        m_new.rob = in_rob_idx; m_new.rd = in_rd; m_new.data = in_data;
        m_q.push_back(m_new);
      end
    end
  end

  // Compare every cycle on the falling edge once the model has seen reset.
  logic exp_req;
  always @(negedge clk) begin
    if (m_live) begin
      exp_req = (m_q.size() > 0) && !(mispredict && flush_mask[m_q[0].rob]);
      chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
      chk("occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("cdb_req", 32'(cdb_req), 32'(exp_req));
      if (exp_req && cdb_req) begin
        chk("cdb_rob_idx", 32'(cdb_rob_idx), 32'(m_q[0].rob));
        chk("cdb_rd", 32'(cdb_rd), 32'(m_q[0].rd));
        chk("cdb_data", cdb_data, m_q[0].data);
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0; in_rob_idx = '0; in_rd = '0; in_data = '0;
    cdb_gnt = 1'b0; mispredict = 1'b0; flush_mask = '0;
  endtask

  task automatic setin(input logic v, input logic [3:0] rob, input logic [6:0] rd,
                       input logic [31:0] d, input logic g, input logic mp, input logic [15:0] mk);
    in_valid = v; in_rob_idx = rob; in_rd = rd; in_data = d;
    cdb_gnt = g; mispredict = mp; flush_mask = mk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive(input logic v, input logic [3:0] rob, input logic [6:0] rd,
                       input logic [31:0] d, input logic g, input logic mp, input logic [15:0] mk);
    setin(v, rob, rd, d, g, mp, mk);
    tick();
  endtask

  task automatic push(input logic [3:0] rob);
    drive(1'b1, rob, 7'(rob + 4'd1), 32'h100 + 32'(rob), 1'b0, 1'b0, '0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // Reset values
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_req", 32'(cdb_req), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_fields", {21'(cdb_rob_idx), cdb_rd}, 32'd0);
    chk("rst_data", cdb_data, 32'd0);

    // Single result with grant held
    drive(1'b1, 4'd3, 7'd10, 32'h0000_0007, 1'b1, 1'b0, '0);
    chk("single_req", 32'(cdb_req), 32'd1);
    chk("single_rob", 32'(cdb_rob_idx), 32'd3);
    chk("single_rd", 32'(cdb_rd), 32'd10);
    chk("single_data", cdb_data, 32'h7);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    chk("single_occ0", 32'(occupancy), 32'd0);
    chk("single_req0", 32'(cdb_req), 32'd0);

    // Fill and stall, then drain in order
    for (int k = 0; k < 4; k++) push(4'(8 + k));
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    chk("unfull_ready", 32'(in_ready), 32'd1);
    chk("unfull_occ", 32'(occupancy), 32'd3);
    for (int k = 1; k < 4; k++) begin
      chk("drain_head", 32'(cdb_rob_idx), 32'(8 + k));
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    end
    chk("drain_occ0", 32'(occupancy), 32'd0);

    // Simultaneous push and pop at occupancy 2
    push(4'd1);
    push(4'd2);
    drive(1'b1, 4'd3, 7'd33, 32'hABCD_0003, 1'b1, 1'b0, '0);
    chk("pp_occ", 32'(occupancy), 32'd2);
    chk("pp_head", 32'(cdb_rob_idx), 32'd2);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    chk("pp_tail", 32'(cdb_rob_idx), 32'd3);
    chk("pp_tail_data", cdb_data, 32'hABCD_0003);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);

    // Selective flush: hold {1,2,5}, incoming 6, flush 2 and 6
    push(4'd1);
    push(4'd2);
    push(4'd5);
    drive(1'b1, 4'd6, 7'd66, 32'h66, 1'b0, 1'b1, 16'h0044);
    chk("flush_occ", 32'(occupancy), 32'd2);
    chk("flush_head", 32'(cdb_rob_idx), 32'd1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    chk("flush_next", 32'(cdb_rob_idx), 32'd5);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    chk("flush_occ0", 32'(occupancy), 32'd0);

    // Head flush concurrent with grant
    push(4'd4);
    push(4'd7);
    setin(1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0010);
    #2;
    chk("hflush_req", 32'(cdb_req), 32'd0);
    tick();
    chk("hflush_occ", 32'(occupancy), 32'd1);
    chk("hflush_req_next", 32'(cdb_req), 32'd1);
    chk("hflush_head", 32'(cdb_rob_idx), 32'd7);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);

    // Pop on unflushed head plus flush of the rest
    push(4'd9);
    push(4'd10);
    push(4'd11);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0400);
    chk("popflush_occ", 32'(occupancy), 32'd1);
    chk("popflush_head", 32'(cdb_rob_idx), 32'd11);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);

    // Flush of everything including the incoming result
    push(4'd1);
    push(4'd2);
    drive(1'b1, 4'd3, 7'd3, 32'h3, 1'b0, 1'b1, 16'hFFFF);
    chk("allflush_occ", 32'(occupancy), 32'd0);
    chk("allflush_req", 32'(cdb_req), 32'd0);

    // Reset mid-operation with a grant pending
    push(4'd12);
    push(4'd13);
    push(4'd14);
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    rst = 1'b0;
    chk("mrst_occ", 32'(occupancy), 32'd0);
    chk("mrst_req", 32'(cdb_req), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
